// File: rtl/cog_led_driver.sv
// Board LED stage for p1v cog activity: synchronises ledg, stretches short runs to a visible
// minimum on-time, and drives active/inactive LED pairs through a global brightness PWM.
module cog_led_driver #(
    parameter int unsigned COGS           = 8,
    parameter int unsigned STRETCH_CYCLES = 16000000,
    parameter int unsigned PWM_BITS       = 8
) (
    input  logic                  clock_160,
    input  logic                  resn,
    input  logic [COGS-1:0]       cogled,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [2*COGS-1:0]     led,
    output logic [COGS-1:0]       cog_active
);

    localparam int unsigned CntW = (STRETCH_CYCLES == 0) ? 1 : $clog2(STRETCH_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(STRETCH_CYCLES);

    logic [COGS-1:0]     sync_q;
    logic [COGS-1:0]     s_q;
    logic [CntW-1:0]     cnt_q [COGS];
    logic [CntW-1:0]     cnt_d [COGS];
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [PWM_BITS-1:0] bright_q;
    logic [PWM_BITS-1:0] bright_d;
    logic                pwm_on;
    logic [2*COGS-1:0]   led_q;
    logic [2*COGS-1:0]   led_d;

    // cogled is asynchronous to clock_160
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            sync_q <= '0;
            s_q    <= '0;
        end else begin
            sync_q <= cogled;
            s_q    <= sync_q;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(COGS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_q[i]) begin
                cnt_d[i] = CntLoad;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            cog_active[i] = s_q[i] | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            for (int i = 0; i < int'(COGS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(COGS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Brightness is only sampled at the period boundary so no runt pulses appear.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        bright_d  = bright_q;
        if (&pwm_cnt_q) begin
            bright_d = brightness;
        end
        pwm_on = (pwm_cnt_q < bright_q);
    end

    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            bright_q  <= bright_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(COGS); i++) begin
            led_d[i]        = ~(cog_active[i] & pwm_on);
            led_d[COGS + i] = ~(~cog_active[i] & pwm_on);
        end
    end

    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            led_q <= '1;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_cog_led_driver.sv
// Bench for cog_led_driver: directed vector tables, hand-written corner sequences and random
// activity checked every cycle against a sample-history reference model.
module tb_cog_led_driver;

    localparam int COGS = 8;
    localparam int S    = 10;
    localparam int PB   = 4;
    localparam int MAXE = 8192;

    logic        clock_160 = 1'b0;
    logic        resn      = 1'b0;
    logic [7:0]  cogled    = '0;
    logic [3:0]  brightness = 4'd15;
    logic [15:0] led;
    logic [7:0]  cog_active;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference history: samples of the inputs at each clock edge since reset release.
    int         n_edges = 0;
    logic [7:0] samp  [MAXE];
    logic [3:0] bsamp [MAXE];

    always #5 clock_160 = ~clock_160;

    cog_led_driver #(
        .COGS           (COGS),
        .STRETCH_CYCLES (S),
        .PWM_BITS       (PB)
    ) dut (
        .clock_160  (clock_160),
        .resn       (resn),
        .cogled     (cogled),
        .brightness (brightness),
        .led        (led),
        .cog_active (cog_active)
    );

    // A cog is active after edge t if any input sample in the last S+1 sampled edges,
    // delayed by the synchroniser, was 1.
    function automatic logic [7:0] m_act(input int t);
        logic [7:0] r;
        r = '0;
        for (int e = t - 1 - S; e <= t - 1; e++) begin
            if (e >= 1) r |= samp[e];
        end
        return r;
    endfunction

    // Brightness takes the value sampled at the latest period boundary edge (multiple of 16).
    function automatic int m_bright(input int t);
        int e;
        e = (t / 16) * 16;
        return (e >= 16) ? int'(bsamp[e]) : 0;
    endfunction

    function automatic logic m_on(input int t);
        return (t % 16) < m_bright(t);
    endfunction

    function automatic logic [15:0] m_led(input int t);
        logic [7:0] a;
        logic       o;
        if (t < 1) return 16'hFFFF;
        a = m_act(t - 1);
        o = m_on(t - 1);
        return {~(~a & {8{o}}), ~(a & {8{o}})};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (edge %0d)", name, got, exp, n_edges);
        end
    endtask

    // One clock: record inputs at the rising edge, compare against the model at the falling edge.
    task automatic tick();
        @(posedge clock_160);
        if (resn && n_edges < MAXE - 1) begin
            n_edges++;
            samp[n_edges]  = cogled;
            bsamp[n_edges] = brightness;
        end
        @(negedge clock_160);
        if (n_edges < MAXE - 1) begin
            chk("led_model", int'(led), int'(m_led(n_edges)));
            chk("active_model", int'(cog_active), int'(m_act(n_edges)));
        end
    endtask

    typedef struct {
        int          cog;
        logic [15:0] pat;
        int          plen;
        int          first;
        int          last;
        int          cnt;
        int          runs;
    } pulse_t;

    typedef struct {
        logic [3:0] bright;
        logic [7:0] cl;
        int         lo0;
        int         lo8;
        int         lo9;
    } duty_t;

    pulse_t ptab [5];
    duty_t  dtab [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, lo8, lo9, first, last, cnt, runs, other, found;
        logic prev, hi;
        pulse_t p;
        duty_t  d;

        ptab[0] = '{3, 16'h0001, 1, 1, 11, 11, 1};
        ptab[1] = '{0, 16'h0107, 9, 1, 19, 19, 1};
        ptab[2] = '{5, 16'h0007, 3, 1, 13, 13, 1};
        ptab[3] = '{6, 16'h0801, 12, 1, 22, 22, 1};
        ptab[4] = '{6, 16'h1001, 13, 1, 23, 22, 2};

        dtab[0] = '{4'd4,  8'h01, 4,  0, 4};
        dtab[1] = '{4'd0,  8'h01, 0,  0, 0};
        dtab[2] = '{4'd15, 8'h01, 15, 0, 15};
        dtab[3] = '{4'd1,  8'h00, 0,  1, 1};
        dtab[4] = '{4'd9,  8'h02, 0,  9, 0};

        // Reset values, then full-brightness all-active pattern
        resn = 1'b0; cogled = 8'hFF; brightness = 4'd15; n_edges = 0;
        repeat (3) tick();
        chk("reset_led", int'(led), 16'hFFFF);
        chk("reset_active", int'(cog_active), 0);
        resn = 1'b1;
        repeat (20) tick();
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("t1_led_hi", int'(led[15:8]), 8'hFF);
            chk("t1_led_lo_uniform", int'(led[7:0] == 8'h00 || led[7:0] == 8'hFF), 1);
            if (led[7:0] == 8'h00) lows++;
        end
        chk("t1_lit_cycles", lows, 15);

        // Stretch and retrigger vectors
        for (int v = 0; v < 5; v++) begin
            p = ptab[v];
            cogled = '0;
            repeat (15) tick();
            first = -1; last = -1; cnt = 0; runs = 0; other = 0; prev = 1'b0;
            for (int k = 0; k < 40; k++) begin
                cogled[p.cog] = (k < p.plen) ? p.pat[k] : 1'b0;
                tick();
                hi = cog_active[p.cog];
                other |= int'(cog_active) & ~(1 << p.cog);
                if (hi) begin
                    cnt++;
                    last = k;
                    if (first < 0) first = k;
                    if (!prev) runs++;
                end
                prev = hi;
            end
            chk($sformatf("pulse%0d_first", v), first, p.first);
            chk($sformatf("pulse%0d_last", v), last, p.last);
            chk($sformatf("pulse%0d_count", v), cnt, p.cnt);
            chk($sformatf("pulse%0d_runs", v), runs, p.runs);
            chk($sformatf("pulse%0d_others", v), other, 0);
        end

        // PWM duty vectors
        for (int v = 0; v < 5; v++) begin
            d = dtab[v];
            brightness = d.bright;
            cogled = d.cl;
            repeat (40) tick();
            lows = 0; lo8 = 0; lo9 = 0;
            for (int k = 0; k < 16; k++) begin
                tick();
                if (!led[0]) lows++;
                if (!led[8]) lo8++;
                if (!led[9]) lo9++;
            end
            chk($sformatf("duty%0d_led0", v), lows, d.lo0);
            chk($sformatf("duty%0d_led8", v), lo8, d.lo8);
            chk($sformatf("duty%0d_led9", v), lo9, d.lo9);
        end

        // Brightness change mid-period only applies after the wrap
        brightness = 4'd15;
        cogled = 8'h01;
        repeat (40) tick();
        found = 0;
        for (int k = 0; k < 32 && found == 0; k++) begin
            if (n_edges % 16 == 5) found = 1;
            else tick();
        end
        chk("bright_sync_found", found, 1);
        brightness = 4'd2;
        lows = 0;
        for (int k = 0; k < 26; k++) begin
            tick();
            if (!led[0]) lows++;
        end
        chk("bright_boundary_lows", lows, 12);

        // Asynchronous reset in the middle of a stretch
        brightness = 4'd15;
        cogled = 8'h80;
        repeat (20) tick();
        cogled = 8'h00;
        repeat (3) tick();
        chk("pre_reset_stretch", int'(cog_active[7]), 1);
        #2;
        resn = 1'b0;
        n_edges = 0;
        #1;
        chk("async_reset_active", int'(cog_active), 0);
        chk("async_reset_led", int'(led), 16'hFFFF);
        repeat (2) tick();
        resn = 1'b1;
        repeat (20) tick();
        chk("post_reset_cog7", int'(cog_active[7]), 0);

        // Random activity against the reference model
        for (int i = 0; i < 1200; i++) begin
            logic [7:0] mask;
            if ($urandom_range(0, 3) == 0) begin
                mask = 8'($urandom);
                if ($urandom_range(0, 3) != 0) mask &= 8'($urandom);
                cogled ^= mask;
            end
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
